// File: rtl/result_drain.sv
// result_drain: unloads the result memory after ap_done and presents the words
// in address order on a valid/ready stream.
//
// Optional feature macro: DRAIN_CHECKSUM_EN (running sum of handshaked words on
// checksum; when undefined checksum is tied to zero).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   ap_done    program-complete pulse; accepted only while idle
//   n          matrix count, sampled with an accepted ap_done (clamped to MAX_N)
//   addrO      output-memory read address (holds last issued address)
//   dataO      read data, valid the cycle after an address is issued
//   m_valid    stream word valid
//   m_ready    stream consumer ready
//   m_data     stream word
//   m_last     final word of the drain
//   busy       high from accepted ap_done until the last word is accepted
//   drain_done one-cycle completion pulse
//   checksum   sum of words handshaked in the current/last drain
module result_drain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WPM    = 16,
  parameter int unsigned MAX_N  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_done,
  input  logic [3:0]        n,
  output logic [ADDR_W-1:0] addrO,
  input  logic [DATA_W-1:0] dataO,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              drain_done,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_total;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_done;

  // 2-entry FIFO holding captured read data plus its last-word flag
  logic [DATA_W-1:0] r_fdata [0:1];
  logic              r_flast [0:1];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic [3:0]        w_n_clamp;
  logic [CNT_W-1:0]  w_total;
  logic              w_hs;
  logic [1:0]        w_credit;
  logic              w_issue;
  logic              w_accept;

  assign w_n_clamp = (n > 4'(MAX_N)) ? 4'(MAX_N) : n;
  assign w_total   = CNT_W'(WPM * 32'(w_n_clamp));
  assign w_accept  = (r_state == S_IDLE) && ap_done;

  assign m_valid   = (r_count != 2'd0);
  assign m_data    = r_fdata[r_rptr];
  assign m_last    = m_valid && r_flast[r_rptr];
  assign w_hs      = m_valid && m_ready;

  // Credit uses post-pop occupancy so a word leaving this cycle frees a slot
  // for an issue in the same cycle; this keeps the stream bubble-free.
  assign w_credit  = r_count + {1'b0, r_inflight} - {1'b0, w_hs};
  assign w_issue   = (r_state == S_RUN) && (w_credit < 2'd2) && (r_rd_ptr < r_total);

  assign addrO      = r_addr;
  assign busy       = (r_state == S_RUN);
  assign drain_done = r_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_total         <= '0;
      r_rd_ptr        <= '0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
      r_fdata[0]      <= '0;
      r_fdata[1]      <= '0;
      r_flast[0]      <= 1'b0;
      r_flast[1]      <= 1'b0;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_count         <= '0;
    end else begin
      r_done <= 1'b0;

      // capture the word addressed in the previous cycle
      if (r_inflight) begin
        r_fdata[r_wptr] <= dataO;
        r_flast[r_wptr] <= r_inflight_last;
        r_wptr          <= ~r_wptr;
      end
      if (w_hs) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_hs};

      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr          <= r_rd_ptr[ADDR_W-1:0];
        r_inflight_last <= (r_rd_ptr == r_total - CNT_W'(1));
        r_rd_ptr        <= r_rd_ptr + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (ap_done) begin
            r_total  <= w_total;
            r_rd_ptr <= '0;
            if (w_total == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_hs && m_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= '0;
    end else if (w_hs) begin
      r_sum <= r_sum + m_data;
    end
  end

  assign checksum = r_sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ap_done;
  logic [3:0]  n;
  logic [6:0]  addrO;
  logic [31:0] dataO;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        drain_done;
  logic [31:0] checksum;

  logic [31:0] mem [0:127];
  exp_t        sb [$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int          cyc = 0;
  int          ap_cyc, first_valid, last_hs, done_cyc;
  int unsigned hs_cnt, valid_cnt, busy_seen, done_cnt;
  logic [31:0] exp_sum;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;

  result_drain #(.DATA_W(32), .ADDR_W(7), .WPM(16), .MAX_N(8)) dut (
    .clk(clk), .rst(rst), .ap_done(ap_done), .n(n), .addrO(addrO),
    .dataO(dataO), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .drain_done(drain_done), .checksum(checksum)
  );

  // memory with data available the cycle after the address is registered
  assign dataO = mem[addrO];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stream monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (ap_done && !busy) ap_cyc = cyc;
      if (busy) busy_seen++;
      if (m_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (m_last) last_hs = cyc;
        if (sb.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          e = sb.pop_front();
          check("data", m_data, e.d);
          check("last", m_last, e.l);
        end
      end
      if (drain_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic start_drain(input logic [3:0] nv);
    exp_t e;
    int unsigned tot;
    tot = 16 * ((nv > 4'd8) ? 8 : int'(nv));
    exp_sum = '0;
    for (int unsigned i = 0; i < tot; i++) begin
      e.d = mem[i];
      e.l = (i == tot - 1);
      sb.push_back(e);
      exp_sum = exp_sum + mem[i];
    end
    hs_cnt = 0; valid_cnt = 0; busy_seen = 0;
    first_valid = -1; last_hs = -1; done_cyc = -1;
    n = nv;
    ap_done = 1'b1;
    @(posedge clk); #1;
    ap_done = 1'b0;
  endtask

  // mode 0: ready held high, 1: toggling, 2: random. inj>0 pulses a stray
  // ap_done (n=3) at that cycle of the wait.
  task automatic wait_done(input int mode, input int limit, input int inj);
    int unsigned d0;
    bit ok;
    d0 = done_cnt;
    ok = 0;
    for (int c = 0; c < limit; c++) begin
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      ap_done = (c == inj);
      if (c == inj) n = 4'd3;
      @(posedge clk); #1;
    end
    ap_done = 1'b0;
    if (!ok) check("timeout", 0, 1);
  endtask

  task automatic end_checks(input string tag, input int unsigned words);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_words"}, hs_cnt, words);
    check({tag, "_busy_end"}, busy, 0);
`ifdef DRAIN_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, exp_sum);
`else
    check({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  initial begin
    rst = 1'b0; ap_done = 1'b0; n = '0; m_ready = 1'b0;
    prev_stall = 1'b0; done_cnt = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'(i) + 32'd100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", addrO, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", drain_done, 0);
    check("rst_checksum", checksum, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: single matrix, consumer always ready
    m_ready = 1'b1;
    start_drain(4'd1);
    wait_done(0, 200, -1);
    // ap_done seen before edge P0; first valid is visible after edge P0+2
    check("t1_latency", first_valid - ap_cyc, 3);
    check("t1_no_bubbles", last_hs - first_valid, 15);
    check("t1_done_gap", done_cyc - last_hs, 1);
    check("t1_last_addr", addrO, 15);
    end_checks("t1", 16);

    // 2: two matrices, ready toggling
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000 + 32'(i * 7);
    start_drain(4'd2);
    wait_done(1, 400, -1);
    end_checks("t2", 32);

    // 3: zero matrices
    m_ready = 1'b1;
    start_drain(4'd0);
    wait_done(0, 20, -1);
    check("t3_done_gap", done_cyc - ap_cyc, 1);
    check("t3_valid_cnt", valid_cnt, 0);
    check("t3_busy_seen", busy_seen, 0);
    end_checks("t3", 0);

    // 4: n above MAX_N clamps to 128 words; stray ap_done mid-drain ignored
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 + 32'(i);
    start_drain(4'd12);
    wait_done(2, 2000, 40);
    check("t4_last_addr", addrO, 127);
    end_checks("t4", 128);
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_restart", busy, 0);

    // 5: reset mid-drain, then restart
    for (int i = 0; i < 128; i++) mem[i] = 32'(i) + 32'd100;
    start_drain(4'd1);
    m_ready = 1'b1;
    for (int c = 0; c < 200 && hs_cnt < 5; c++) begin
      @(posedge clk); #1;
    end
    check("t5_five_words", hs_cnt, 5);
    m_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_valid", m_valid, 0);
    check("t5_addr", addrO, 0);
    check("t5_busy", busy, 0);
    sb.delete();
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    start_drain(4'd1);
    wait_done(0, 200, -1);
    end_checks("t5", 16);

    // 6: all-ones data wraps the checksum
    for (int i = 0; i < 128; i++) mem[i] = 32'hFFFF_FFFF;
    start_drain(4'd1);
    wait_done(0, 200, -1);
    end_checks("t6", 16);
`ifdef DRAIN_CHECKSUM_EN
    check("t6_checksum_val", checksum, 32'hFFFF_FFF0);
`else
    check("t6_checksum_val", checksum, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
